dist16_4: RTL and testbench

//   1-to-4 distributor for 16-bit words; the sequential counterpart of the 4:1 16-bit select mux.

---
 rtl/dist16_4_pkg.sv | 17 +
 rtl/dist_lane_fifo.sv | 71 +++++++
 rtl/dist16_4.sv | 56 +++++
 tb/tb_dist16_4.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/dist16_4_pkg.sv
// Shared constants and helpers for the 1-to-4 word distributor.
package dist16_4_pkg;

  localparam int LANES     = 4;
  localparam int SEL_W     = 2;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 2;

  // One-hot lane decode, all zero when the enable is low.
  function automatic logic [LANES-1:0] lane_decode(input logic [SEL_W-1:0] sel,
                                                   input logic             en);
    logic [LANES-1:0] onehot;
    onehot = {{(LANES-1){1'b0}}, 1'b1} << sel;
    return en ? onehot : '0;
  endfunction

endpackage

// File: rtl/dist_lane_fifo.sv
// Single-lane FIFO built from flip-flops. The head word is always presented on rdata.
module dist_lane_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    head_reg;
  logic [PW-1:0]    tail_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  // Guards keep the FIFO self-protecting even if the caller does not qualify push/pop.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_reg[head_reg];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Each storage entry loads when the tail points at it during an accepted push.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mem_reg[gi] <= '0;
        end else if (do_push && (tail_reg == PW'(gi))) begin
          mem_reg[gi] <= wdata;
        end
      end
    end
  endgenerate

  // Head/tail pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg <= '0;
      tail_reg <= '0;
    end else begin
      if (do_push) tail_reg <= tail_reg + 1'b1;
      if (do_pop)  head_reg <= head_reg + 1'b1;
    end
  end

  // Occupancy count; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/dist16_4.sv
// 1-to-4 distributor: one valid/ready input steered by in_sel into four lane FIFOs.
module dist16_4
  import dist16_4_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic [WIDTH-1:0] out1_data,
  output logic [WIDTH-1:0] out2_data,
  output logic [WIDTH-1:0] out3_data,
  output logic [LANES-1:0] out_valid,
  input  logic [LANES-1:0] out_ready,
  output logic [LANES-1:0] lane_full
);

  logic [LANES-1:0] push_vec;
  logic [LANES-1:0] lane_empty;
  logic [WIDTH-1:0] lane_data [LANES];

  // in_ready looks only at registered fullness, so a same-cycle pop never frees a slot early.
  assign in_ready = ~lane_full[in_sel];
  assign push_vec = lane_decode(in_sel, in_valid & in_ready);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      dist_lane_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_vec[gi]),
        .wdata (in_data),
        .pop   (out_ready[gi] & out_valid[gi]),
        .rdata (lane_data[gi]),
        .empty (lane_empty[gi]),
        .full  (lane_full[gi])
      );
      assign out_valid[gi] = ~lane_empty[gi];
    end
  endgenerate

  assign out0_data = lane_data[0];
  assign out1_data = lane_data[1];
  assign out2_data = lane_data[2];
  assign out3_data = lane_data[3];

endmodule

// File: tb/tb_dist16_4.sv
// Testbench for dist16_4: directed vectors, random backpressure, per-lane scoreboard.
module tb_dist16_4;

  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out0_data, out1_data, out2_data, out3_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [3:0]  lane_full;

  logic [15:0] od [4];
  logic [15:0] exp_q [4][$];
  int          push_cnt [4];
  int          checks;
  int          errors;
  bit          verbose;
  bit          stalled;
  logic [15:0] mon_exp;

  dist16_4 dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out0_data (out0_data),
    .out1_data (out1_data),
    .out2_data (out2_data),
    .out3_data (out3_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lane_full (lane_full)
  );

  assign od[0] = out0_data;
  assign od[1] = out1_data;
  assign od[2] = out2_data;
  assign od[3] = out3_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: at the falling edge, score the pops and record the pushes the next rising edge will commit.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) exp_q[i].delete();
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          checks++;
          if (exp_q[i].size() == 0) begin
            errors++;
            $display("FAIL pop_lane%0d: got %h, required no word (scoreboard empty)", i, od[i]);
          end else begin
            mon_exp = exp_q[i].pop_front();
            if (od[i] !== mon_exp) begin
              errors++;
              $display("FAIL pop_lane%0d: got %h, required %h", i, od[i], mon_exp);
            end else if (verbose) begin
              $display("lane %0d pop %h", i, od[i]);
            end
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q[in_sel].push_back(in_data);
        push_cnt[in_sel]++;
        if (verbose) $display("lane %0d push %h", in_sel, in_data);
      end
    end
  end

  initial begin
    checks    = 0;
    errors    = 0;
    verbose   = 1'b1;
    stalled   = 1'b0;
    for (int i = 0; i < 4; i++) push_cnt[i] = 0;
    rst       = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    in_valid  = 1'b0;
    out_ready = '0;

    // 1. reset asserted mid-cycle takes effect immediately
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_lane_full", 32'(lane_full), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_out0_data", 32'(out0_data), 32'h0);
    tick;
    tick;
    rst = 1'b0;
    tick;

    // 2. single word to lane 2
    in_sel = 2'd2; in_data = 16'hA5A5; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    check("t2_out_valid", 32'(out_valid), 32'h4);
    check("t2_out2_data", 32'(out2_data), 32'hA5A5);
    out_ready = 4'b0100;
    tick;
    out_ready = 4'b0000;
    check("t2_drained", 32'(out_valid), 32'h0);

    // 3. fill lane 1, check full/in_ready per select, drain in order
    in_sel = 2'd1; in_data = 16'h0001; in_valid = 1'b1;
    tick;
    in_data = 16'h0002;
    tick;
    in_valid = 1'b0;
    check("t3_lane_full", 32'(lane_full), 32'h2);
    check("t3_out1_head", 32'(out1_data), 32'h0001);
    #1;
    check("t3_ready_sel1", 32'(in_ready), 32'h0);
    in_sel = 2'd0;
    #1;
    check("t3_ready_sel0", 32'(in_ready), 32'h1);
    out_ready = 4'b0010;
    tick;
    check("t3_out1_second", 32'(out1_data), 32'h0002);
    check("t3_not_full", 32'(lane_full), 32'h0);
    tick;
    out_ready = 4'b0000;
    check("t3_drained", 32'(out_valid), 32'h0);

    // 4. push to full lane 3 while it pops: push stalls one cycle
    in_sel = 2'd3; in_data = 16'h3001; in_valid = 1'b1;
    tick;
    in_data = 16'h3002;
    tick;
    in_data = 16'h3003; out_ready = 4'b1000;
    #1;
    check("t4_stall_ready", 32'(in_ready), 32'h0);
    tick;
    check("t4_after_pop_full", 32'(lane_full), 32'h0);
    check("t4_after_pop_head", 32'(out3_data), 32'h3002);
    out_ready = 4'b0000;
    #1;
    check("t4_retry_ready", 32'(in_ready), 32'h1);
    tick;
    in_valid = 1'b0;
    check("t4_refull", 32'(lane_full), 32'h8);
    check("t4_valid", 32'(out_valid), 32'h8);
    out_ready = 4'b1000;
    tick;
    tick;
    out_ready = 4'b0000;
    check("t4_drained", 32'(out_valid), 32'h0);

    // 5. random traffic with backpressure; source holds data/sel while stalled
    verbose = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (!stalled) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel   = 2'($urandom_range(0, 3));
        in_data  = 16'($urandom);
      end
      out_ready = 4'($urandom);
      #1;
      stalled = in_valid && !in_ready;
      tick;
    end
    in_valid  = 1'b0;
    out_ready = 4'b1111;
    repeat (4) tick;
    out_ready = 4'b0000;
    check("t5_drained", 32'(out_valid), 32'h0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t5_q%0d_empty", i), 32'(exp_q[i].size()), 32'h0);
      check($sformatf("t5_wraps_lane%0d", i), 32'(push_cnt[i] > 202), 32'h1);
    end

    // 6. reset with lanes partially full, then BEEF comes out first on lane 0
    verbose = 1'b1;
    in_valid = 1'b1;
    in_sel = 2'd0; in_data = 16'h1111; tick;
    in_sel = 2'd1; in_data = 16'h2222; tick;
    in_sel = 2'd2; in_data = 16'h3333; tick;
    in_sel = 2'd0; in_data = 16'h4444; tick;
    in_valid = 1'b0;
    check("t6_prefill", 32'(out_valid), 32'h7);
    check("t6_prefill_full", 32'(lane_full), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'h0);
    check("t6_rst_full", 32'(lane_full), 32'h0);
    check("t6_rst_ready", 32'(in_ready), 32'h1);
    check("t6_rst_out0", 32'(out0_data), 32'h0);
    tick;
    tick;
    rst = 1'b0;
    in_sel = 2'd0; in_data = 16'hBEEF; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    check("t6_beef_data", 32'(out0_data), 32'hBEEF);
    check("t6_beef_valid", 32'(out_valid), 32'h1);
    out_ready = 4'b0001;
    tick;
    out_ready = 4'b0000;
    check("t6_drained", 32'(out_valid), 32'h0);
    check("t6_q0_empty", 32'(exp_q[0].size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
